// File: rtl/mboot_ctrl.sv
// Multiboot controller: debounced select/reboot keys drive the EG_LOGIC_MBOOT
// image address and a confirmed rebootn pulse. Define MBOOT_LED_EN for the RGB indicator.
module mboot_debounce #(
    parameter int CYC = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_i,
    output logic level_o
);
    localparam int CW = $clog2(CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYC - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], key_i};
            // Level flips only on the CYC-th consecutive differing sample.
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
endmodule

module mboot_ctrl #(
    parameter int         DEBOUNCE_CYC = 240000,
    parameter int         HOLD_CYC     = 24000000,
    parameter int         PULSE_CYC    = 16,
    parameter int         NUM_IMAGES   = 4,
    parameter logic [7:0] BASE_ADDR    = 8'h00,
    parameter logic [7:0] ADDR_STRIDE  = 8'h0A
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       key_sel,
    input  logic       key_boot,
    output logic [7:0] dynamic_addr,
    output logic       rebootn,
    output logic [2:0] RGB_LED
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int PW = $clog2(PULSE_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_IMAGES - 1);

    typedef enum logic [1:0] {IDLE, CONFIRM, PULSE, DONE} state_t;

    state_t        state_q;
    logic [2:0]    idx_q;
    logic [HW-1:0] hold_q;
    logic [PW-1:0] pulse_q;
    logic          rebootn_q;
    logic [7:0]    addr_q;
    logic [7:0]    addr_d;
    logic          sel_lvl, boot_lvl, sel_prev_q, boot_prev_q;
    logic          sel_press, boot_press;

    mboot_debounce #(.CYC(DEBOUNCE_CYC)) u_db_sel (
        .clk_i(CLK_IN), .rst_n_i(RST_N), .key_i(key_sel), .level_o(sel_lvl)
    );
    mboot_debounce #(.CYC(DEBOUNCE_CYC)) u_db_boot (
        .clk_i(CLK_IN), .rst_n_i(RST_N), .key_i(key_boot), .level_o(boot_lvl)
    );

    assign sel_press  = sel_prev_q & ~sel_lvl;
    assign boot_press = boot_prev_q & ~boot_lvl;
    assign addr_d     = BASE_ADDR + {5'd0, idx_q} * ADDR_STRIDE;

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            pulse_q     <= '0;
            rebootn_q   <= 1'b1;
            addr_q      <= BASE_ADDR;
            sel_prev_q  <= 1'b1;
            boot_prev_q <= 1'b1;
        end else begin
            sel_prev_q  <= sel_lvl;
            boot_prev_q <= boot_lvl;
            addr_q      <= addr_d;
            case (state_q)
                IDLE: begin
                    // Boot press takes priority over a coincident select press.
                    if (boot_press) begin
                        state_q <= CONFIRM;
                        hold_q  <= '0;
                    end else if (sel_press) begin
                        idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                    end
                end
                CONFIRM: begin
                    if (boot_lvl) begin
                        state_q <= IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        state_q   <= PULSE;
                        pulse_q   <= '0;
                        rebootn_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                PULSE: begin
                    if (pulse_q == PULSE_LAST) begin
                        state_q   <= DONE;
                        rebootn_q <= 1'b1;
                    end else begin
                        pulse_q <= pulse_q + 1'b1;
                    end
                end
                default: ;  // DONE: wait for reconfiguration
            endcase
        end
    end

    assign dynamic_addr = addr_q;
    assign rebootn      = rebootn_q;

`ifdef MBOOT_LED_EN
    logic [2:0] led_q;
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) led_q <= 3'b001;
        else        led_q <= (state_q == PULSE || state_q == DONE) ? 3'b111 : idx_q + 3'd1;
    end
    assign RGB_LED = led_q;
`else
    assign RGB_LED = 3'b000;
`endif
endmodule
